// File: rtl/keypad_pkg.sv
// Shared types and key decode for the 4x4 keypad entry block.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } key_state_t;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_class_t;

  // Keypad position {row, col} to hex nibble; '*' reads as E and '#' as F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] nib;
    nib = '0;
    case ({r, c})
      4'h0: nib = 4'h1;
      4'h1: nib = 4'h2;
      4'h2: nib = 4'h3;
      4'h3: nib = 4'hA;
      4'h4: nib = 4'h4;
      4'h5: nib = 4'h5;
      4'h6: nib = 4'h6;
      4'h7: nib = 4'hB;
      4'h8: nib = 4'h7;
      4'h9: nib = 4'h8;
      4'hA: nib = 4'h9;
      4'hB: nib = 4'hC;
      4'hC: nib = 4'hE;
      4'hD: nib = 4'h0;
      4'hE: nib = 4'hF;
      4'hF: nib = 4'hD;
      default: nib = '0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row scanner, column synchronizer and per-frame press classifier.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   col,
  output logic [3:0]   row,
  output logic         frame_done,
  output frame_class_t frame_class,
  output logic [1:0]   frame_r,
  output logic [1:0]   frame_c
);

  localparam int unsigned DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

  logic [DWELL_W-1:0] dwell;
  logic [1:0]         row_idx;
  logic [3:0]         col_meta;
  logic [3:0]         col_sync;
  logic               sample;

  // Low-bit tally so far this frame: 0, 1 (position in acc_r/acc_c) or 2 meaning two or more.
  logic [1:0] acc_cnt;
  logic [1:0] acc_r;
  logic [1:0] acc_c;

  logic [2:0] low_cnt;
  logic [1:0] low_pos;
  logic [1:0] tot_cnt;
  logic [1:0] nxt_r;
  logic [1:0] nxt_c;

  assign row    = ~(4'b0001 << row_idx);
  assign sample = (dwell == DWELL_LAST);

  // Two-flop synchronizer; idle (pulled-up) columns read as ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  // Dwell counter and row index; the row advances on its last dwell cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      dwell   <= dwell + DWELL_W'(1);
    end
  end

  // Fold the current row sample into the running frame tally.
  always_comb begin
    low_cnt = '0;
    low_pos = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_sync[i]) begin
        low_cnt = low_cnt + 3'd1;
        low_pos = 2'(i);
      end
    end
    tot_cnt = acc_cnt;
    nxt_r   = acc_r;
    nxt_c   = acc_c;
    if (low_cnt >= 3'd2 || (low_cnt == 3'd1 && acc_cnt != 2'd0)) begin
      tot_cnt = 2'd2;
    end else if (low_cnt == 3'd1) begin
      tot_cnt = 2'd1;
      nxt_r   = row_idx;
      nxt_c   = low_pos;
    end
  end

  // Accumulate row samples; publish the frame class on the row-3 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt     <= '0;
      acc_r       <= '0;
      acc_c       <= '0;
      frame_done  <= 1'b0;
      frame_class <= FRAME_NONE;
      frame_r     <= '0;
      frame_c     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (sample) begin
        if (row_idx == 2'd3) begin
          frame_done <= 1'b1;
          frame_r    <= nxt_r;
          frame_c    <= nxt_c;
          acc_cnt    <= '0;
          case (tot_cnt)
            2'd0:    frame_class <= FRAME_NONE;
            2'd1:    frame_class <= FRAME_SINGLE;
            default: frame_class <= FRAME_MULTI;
          endcase
        end else begin
          acc_cnt <= tot_cnt;
          acc_r   <= nxt_r;
          acc_c   <= nxt_c;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad press debouncer and two-nibble entry shift register.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       key_held,
  output logic [7:0] entry
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic         frame_done;
  frame_class_t frame_class;
  logic [1:0]   frame_r;
  logic [1:0]   frame_c;

  key_state_t       state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       code_n;
  logic [7:0]       entry_n;
  logic             held_n;
  logic             accept;
  logic             release_key;
  logic             frame_single;
  logic             frame_none;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .row        (row),
    .frame_done (frame_done),
    .frame_class(frame_class),
    .frame_r    (frame_r),
    .frame_c    (frame_c)
  );

  assign frame_single = (frame_class == FRAME_SINGLE);
  assign frame_none   = (frame_class == FRAME_NONE);

  // State, candidate, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cand       <= '0;
      cnt        <= '0;
      key_code   <= '0;
      entry      <= '0;
      key_strobe <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      cnt        <= cnt_n;
      key_code   <= code_n;
      entry      <= entry_n;
      key_strobe <= accept;
      key_held   <= held_n;
    end
  end

  // Per-frame debounce decisions; accept and release drive the output updates.
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    accept      = 1'b0;
    release_key = 1'b0;
    cnt_inc     = cnt + CNT_ONE;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (frame_single) begin
            cand_n = {frame_r, frame_c};
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = ST_HELD;
              cnt_n   = '0;
            end else begin
              state_n = ST_DEBOUNCE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_single) begin
            if ({frame_r, frame_c} == cand) begin
              if (cnt_inc == CNT_DONE) begin
                accept  = 1'b1;
                state_n = ST_HELD;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt_inc;
              end
            end else begin
              cand_n = {frame_r, frame_c};
              cnt_n  = CNT_ONE;
            end
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_HELD: begin
          if (frame_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n     = ST_IDLE;
              release_key = 1'b1;
              cnt_n       = '0;
            end else begin
              state_n = ST_RELEASE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_none) begin
            if (cnt_inc == CNT_DONE) begin
              state_n     = ST_IDLE;
              release_key = 1'b1;
              cnt_n       = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Accepted key updates code and entry; held tracks accept/release.
  always_comb begin
    code_n  = accept ? key_map(frame_r, frame_c) : key_code;
    entry_n = accept ? {entry[3:0], code_n} : entry;
    held_n  = key_held;
    if (accept) begin
      held_n = 1'b1;
    end else if (release_key) begin
      held_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: frame-aligned key stimulus, run-length reference model.
module tb_keypad_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 2;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_strobe;
  logic       key_held;
  logic [7:0] entry;

  keypad_entry #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_strobe(key_strobe),
    .key_held  (key_held),
    .entry     (entry)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: bit r*4+c set means that switch is closed.
  logic [15:0] pressed = '0;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col[c] = 1'b0;
  end

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] entry;
  } exp_t;

  exp_t exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int n_strobes  = 0;
  int n_expected = 0;

  // Reference model state: armed = ready for a new press.
  bit         armed     = 1'b1;
  int         run       = 0;
  int         empty_run = 0;
  int         last_k    = -1;
  logic [7:0] m_entry   = '0;
  bit         m_held    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  // One frame of keypad contents: a press is accepted after DB consecutive frames with
  // that key alone; the next press needs DB consecutive empty frames first.
  task automatic model_frame(input logic [15:0] keys);
    int n;
    int k;
    n = $countones(keys);
    k = -1;
    for (int i = 0; i < 16; i++) if (keys[i]) k = i;
    if (armed) begin
      if (n == 1) begin
        if (run > 0 && k == last_k) run++;
        else run = 1;
        last_k = k;
        if (run == int'(DB)) begin
          m_entry = {m_entry[3:0], kmap[k]};
          exp_q.push_back('{code: kmap[k], entry: m_entry});
          n_expected++;
          armed     = 1'b0;
          empty_run = 0;
          run       = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      if (n == 0) begin
        empty_run++;
        if (empty_run == int'(DB)) begin
          armed = 1'b1;
          run   = 0;
        end
      end else begin
        empty_run = 0;
      end
    end
    m_held = !armed;
  endtask

  // Starts right after a frame boundary; holds keys for one whole frame.
  task automatic run_frame(input logic [15:0] keys);
    pressed = keys;
    @(posedge clk);
    #1;
    check("key_held", key_held, m_held);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    model_frame(keys);
  endtask

  task automatic run_frames(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_frame(keys);
  endtask

  // Asynchronous reset part-way into a frame; leaves the bench at a negedge ready for frame 0.
  task automatic reset_mid(input int edges);
    repeat (edges) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_row", row, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_entry", entry, 8'h00);
    check("rst_strobe", key_strobe, 1'b0);
    check("rst_held", key_held, 1'b0);
    armed     = 1'b1;
    run       = 0;
    empty_run = 0;
    last_k    = -1;
    m_entry   = '0;
    m_held    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every strobe pops one expected acceptance.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && key_strobe) begin
      n_strobes++;
      check("strobe_width", prev_strobe, 1'b0);
      check("held_with_strobe", key_held, 1'b1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe key_code=%0h entry=%0h, required no strobe (t=%0t)",
                 key_code, entry, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_key_code", key_code, e.code);
        check("sb_entry", entry, e.entry);
      end
    end
    prev_strobe = key_strobe && !rst;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int sel;
    int len;
    int a;
    int b;
    logic [15:0] keys;

    // 1: reset state, then reset asserted mid-scan
    rst     = 1'b1;
    pressed = '0;
    #1;
    check("init_row", row, 4'b1110);
    check("init_entry", entry, 8'h00);
    check("init_strobe", key_strobe, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame('0);
    reset_mid(6);

    // 2: single press of row1/col2
    base = n_expected;
    run_frames(key(1, 2), 5);
    run_frames('0, 3);
    check("p2_key_code", key_code, 4'h6);
    check("p2_entry", entry, 8'h06);
    check("p2_strobes", n_expected - base, 1);

    // 3: two-key entry '1' then 'A'
    base = n_expected;
    run_frames(key(0, 0), 3);
    run_frames('0, 3);
    run_frames(key(0, 3), 3);
    run_frames('0, 3);
    check("p3_entry", entry, 8'h1A);
    check("p3_strobes", n_expected - base, 2);

    // 4: bounce on '5', then a one-frame dropout while held
    base = n_expected;
    for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? key(1, 1) : 16'h0);
    check("p4_bounce_strobes", n_expected - base, 0);
    run_frames(key(1, 1), 3);
    run_frame('0);
    run_frames(key(1, 1), 2);
    run_frames('0, 3);
    check("p4_key_code", key_code, 4'h5);
    check("p4_strobes", n_expected - base, 1);

    // 5: two keys together, then one released
    base = n_expected;
    run_frames(key(0, 0) | key(2, 1), 3);
    check("p5_multi_strobes", n_expected - base, 0);
    run_frames(key(2, 1), 3);
    run_frames('0, 3);
    check("p5_key_code", key_code, 4'h8);
    check("p5_strobes", n_expected - base, 1);

    // 6: reset during debounce of '9'
    base = n_expected;
    run_frame(key(2, 2));
    reset_mid(5);
    run_frame(key(2, 2));
    run_frames('0, 3);
    check("p6_strobes", n_expected - base, 0);
    check("p6_entry", entry, 8'h00);

    // Randomized key segments
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 4);
      if (sel < 40) begin
        keys = '0;
      end else if (sel < 85) begin
        keys = key($urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        a    = $urandom_range(0, 15);
        b    = (a + $urandom_range(1, 15)) % 16;
        keys = 16'(1) << a;
        keys = keys | (16'(1) << b);
      end
      run_frames(keys, len);
    end
    run_frames('0, 3);

    check("queue_drained", exp_q.size(), 0);
    check("strobe_count", n_strobes, n_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

- Input-side counterpart to the calculator's multiplexed seven-segment display driver.
- Drives the rows of a 4x4 matrix keypad one at a time and samples its columns. Debounces and decodes single key presses into hex nibbles, and shifts each accepted nibble into an 8-bit entry value.
- The entry value feeds the operand registers in place of the slide switches. Operand capture is still done by the existing debounced load buttons.

## Interface

Parameters:
- SCAN_DIV, 100000: clock cycles each row is driven (dwell time); must be ≥ 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan frames needed to accept a press or a release; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- rst  in  1  asynchronous, active-high reset.
- col  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- row  out  4  keypad rows, active-low, one-hot-low.
- key_code  out  4  nibble of the last accepted key.
- key_strobe  out  1  one-cycle pulse per accepted key.
- key_held  out  1  high from acceptance until the release is debounced.
- entry  out  8  shift register of the last two accepted nibbles.

## Operation

**Scan**
- A row index (0..3) advances every SCAN_DIV cycles and wraps from 3 to 0.
- row = ~(4'b0001 << index).
- col passes through a 2-flop synchronizer.
- The synchronized col is sampled on the last dwell cycle of each row.

**Frame**
- A frame is four row samples, rows 0 to 3. It completes on the row-3 sample.
- Each frame is classified as NONE, SINGLE(r,c) or MULTI:
  - NONE: zero low column bits across all rows.
  - SINGLE(r,c): exactly one low column bit.
  - MULTI: two or more low column bits.

**Key map** (row r, col c → nibble)
- Row 0: 1 2 3 A
- Row 1: 4 5 6 B
- Row 2: 7 8 9 C
- Row 3: E 0 F D (* = E, # = F)

**FSM**
The FSM is evaluated only on frame completion. States are IDLE, DEBOUNCE, HELD and RELEASE.
- IDLE:
  - SINGLE k → DEBOUNCE with cand = k, cnt = 1.
  - If DEBOUNCE_SCANS = 1, accept immediately and go to HELD.
- DEBOUNCE:
  - SINGLE cand → cnt + 1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
  - SINGLE k ≠ cand → restart with cand = k, cnt = 1.
  - NONE or MULTI → IDLE.
- HELD:
  - NONE → RELEASE with cnt = 1. If DEBOUNCE_SCANS = 1, go directly to IDLE.
  - SINGLE or MULTI → stay. Extra or different keys are ignored.
- RELEASE:
  - NONE → cnt + 1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
  - SINGLE or MULTI → HELD, with no new strobe.

**Accept action**
- key_code ← map(cand).
- entry ← {entry[3:0], map(cand)}.
- key_strobe = 1 for exactly one cycle.
- key_held ← 1.

**Release**
- key_held ← 0 on entry to IDLE from RELEASE, or from HELD when DEBOUNCE_SCANS = 1.

**Arithmetic**
- The debounce counter is wide enough to hold DEBOUNCE_SCANS.
- The dwell counter is wide enough to hold SCAN_DIV−1.
- Neither counter saturates or overflows in normal operation.

## Timing

**Reset values** (rst asserted asynchronously)
- row = 4'b1110, i.e. index 0 driven.
- key_code = 0, entry = 0, key_strobe = 0, key_held = 0.
- FSM = IDLE, all counters = 0, synchronizer flops = 4'b1111.

**Cycle relationships**
- Frame length is 4·SCAN_DIV cycles. Every frame of any length starts at row 0 after reset.
- key_strobe, key_code, entry and key_held update on the clock edge after the row-3 sample of the accepting frame.
- key_code and entry are stable from that edge onward.

**Latency**
- A press stable before a frame starts is accepted DEBOUNCE_SCANS frames later, plus 1 cycle.
- A press that begins mid-frame needs up to one extra frame.
- col changes within 2 cycles of a sample point may or may not be seen in that sample. Either outcome is legal.

**Rates and mid-operation reset**
- At most one strobe per press/release cycle.
- Holding a key never auto-repeats.
- rst mid-operation abandons any candidate. No strobe results from a press that straddles reset deassertion until the key has been released and pressed again, or until it is seen in DEBOUNCE_SCANS full post-reset frames.

## Structure

**Shared header/package `keypad_pkg`**
- FSM state encodings.
- Frame class constants: NONE, SINGLE, MULTI.
- The key-map function from {r,c} to nibble.

**Sub-module `keypad_scan`**
- Contains the row counter, dwell counter, synchronizer and frame classifier.
- Outputs a frame_done pulse, the frame class, and r/c.
- `keypad_entry` holds the FSM and the output registers.

## Test plan

All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 2, giving a 16-cycle frame.

1. **Reset:** assert rst mid-scan, col = 4'hF → row = 4'b1110 immediately; key_code, entry, key_strobe and key_held all = 0.
2. **Single press:** hold row1/col2 low for 5 frames, then release → one key_strobe, key_code = 4'h6, entry = 8'h06. key_held rises with the strobe and falls 2 frames after release plus 1 cycle.
3. **Two-key entry:** press '1', release, then press row0/col3 ('A') → entry = 8'h1A, exactly 2 strobes.
4. **Bounce:** alternate key '5' present/absent on every frame for 8 frames → no strobe. In HELD, drop the key for 1 frame and restore it → no second strobe.
5. **Multi-key:** hold row0/col0 and row2/col1 together → no strobe. Release row0/col0 → '8' is accepted 2 frames later, key_code = 4'h8.
6. **Reset mid-DEBOUNCE:** assert rst after the first frame of key '9' → outputs zero immediately. Release the key before 2 post-reset frames → no strobe.
